// File: rtl/mem_defs.sv
// ---------------------------------------------------------------------------
// Module   : mem_defs (package)
// Brief    : Shared FSM encoding and defaults for the MEM-stage data-memory
//            controller.
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mem_defs;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUS  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [3:0] FORBID_NIB_DEF = 4'h4;
  localparam int         TIMEOUT_DEF    = 16;

endpackage

`default_nettype wire

// File: rtl/mem_timeout_cnt.sv
// ---------------------------------------------------------------------------
// Module   : mem_timeout_cnt
// Brief    : Bus-wait counter with clear/enable; flags terminal count at
//            TIMEOUT-1.
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_timeout_cnt
  import mem_defs::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int                 CNT_W  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0]   TC_VAL = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tc_o = (cnt_q == TC_VAL);

endmodule

`default_nettype wire

// File: rtl/data_mem_ctrl.sv
// ---------------------------------------------------------------------------
// Module   : data_mem_ctrl
// Brief    : MEM-stage req/ack bus master; stalls the pipeline while a data
//            transaction is in flight and blocks the forbidden region.
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module data_mem_ctrl
  import mem_defs::*;
#(
  parameter int         ADDR_W     = 6,
  parameter int         TIMEOUT    = TIMEOUT_DEF,
  parameter logic [3:0] FORBID_NIB = FORBID_NIB_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemRead_mem,
  input  logic              MemWrite_mem,
  input  logic [31:0]       Addr_mem,
  input  logic [31:0]       MemWriteData_mem,
  output logic [31:0]       MemDout_mem,
  output logic              MemStall,
  output logic              AccessErr,
  output logic              BusErr,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [31:0]       bus_wdata,
  input  logic              bus_ack,
  input  logic [31:0]       bus_rdata
);

  logic [1:0]        state_q;
  logic              bus_req_q;
  logic              bus_we_q;
  logic [ADDR_W-1:0] bus_addr_q;
  logic [31:0]       bus_wdata_q;
  logic [31:0]       dout_q;
  logic              access_err_q;
  logic              bus_err_q;

  logic req;
  logic forbid;
  logic in_idle;
  logic in_bus;
  logic start;
  logic blocked;
  logic tc;
  logic cnt_en;
  logic unused_addr;

  assign req     = MemRead_mem | MemWrite_mem;
  assign forbid  = (Addr_mem[31:28] == FORBID_NIB);
  assign in_idle = (state_q == S_IDLE);
  assign in_bus  = (state_q == S_BUS);
  assign start   = in_idle & req & ~forbid;
  assign blocked = in_idle & req & forbid;
  assign cnt_en  = in_bus & ~bus_ack & ~tc;

  // Only the word-address slice and the region nibble are decoded.
  assign unused_addr = ^Addr_mem;

  mem_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_cnt (
    .clk_i  (clk),
    .rst_ni (reset),
    .clr_i  (start),
    .en_i   (cnt_en),
    .tc_o   (tc)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      bus_req_q    <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_addr_q   <= '0;
      bus_wdata_q  <= '0;
      dout_q       <= '0;
      access_err_q <= 1'b0;
      bus_err_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            bus_req_q   <= 1'b1;
            bus_we_q    <= MemWrite_mem;
            bus_addr_q  <= Addr_mem[ADDR_W+1:2];
            bus_wdata_q <= MemWriteData_mem;
            state_q     <= S_BUS;
          end else if (blocked) begin
            access_err_q <= 1'b1;
            dout_q       <= '0;
          end
        end
        S_BUS: begin
          if (bus_ack) begin
            if (!bus_we_q) begin
              dout_q <= bus_rdata;
            end
            bus_req_q <= 1'b0;
            state_q   <= S_DONE;
          end else if (tc) begin
            bus_req_q <= 1'b0;
            dout_q    <= '0;
            bus_err_q <= 1'b1;
            state_q   <= S_DONE;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q   <= S_IDLE;
          bus_req_q <= 1'b0;
        end
      endcase
    end
  end

  // A blocked access must hand zero to MEM/WB in the same cycle it retires.
  assign MemDout_mem = blocked ? 32'd0 : dout_q;
  assign MemStall    = reset & (start | in_bus);
  assign AccessErr   = access_err_q;
  assign BusErr      = bus_err_q;
  assign bus_req     = bus_req_q;
  assign bus_we      = bus_we_q;
  assign bus_addr    = bus_addr_q;
  assign bus_wdata   = bus_wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_data_mem_ctrl.sv
// ---------------------------------------------------------------------------
// Module   : tb_data_mem_ctrl
// Brief    : Directed self-checking bench for data_mem_ctrl.
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_data_mem_ctrl;

  logic        clk;
  logic        reset;
  logic        MemRead_mem;
  logic        MemWrite_mem;
  logic [31:0] Addr_mem;
  logic [31:0] MemWriteData_mem;
  logic [31:0] MemDout_mem;
  logic        MemStall;
  logic        AccessErr;
  logic        BusErr;
  logic        bus_req;
  logic        bus_we;
  logic [5:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  int checks = 0;
  int errors = 0;

  data_mem_ctrl #(
    .ADDR_W     (6),
    .TIMEOUT    (16),
    .FORBID_NIB (4'h4)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .MemRead_mem      (MemRead_mem),
    .MemWrite_mem     (MemWrite_mem),
    .Addr_mem         (Addr_mem),
    .MemWriteData_mem (MemWriteData_mem),
    .MemDout_mem      (MemDout_mem),
    .MemStall         (MemStall),
    .AccessErr        (AccessErr),
    .BusErr           (BusErr),
    .bus_req          (bus_req),
    .bus_we           (bus_we),
    .bus_addr         (bus_addr),
    .bus_wdata        (bus_wdata),
    .bus_ack          (bus_ack),
    .bus_rdata        (bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wd);
    MemRead_mem      = rd;
    MemWrite_mem     = wr;
    Addr_mem         = addr;
    MemWriteData_mem = wd;
  endtask

  // Acts as the slave: acks after 'waits' extra BUS cycles (waits<0: never).
  // Returns at the negedge of the first non-stalled cycle after the bus ran.
  task automatic run_bus(input int waits, input logic [31:0] rdata,
                         input logic ack_in_done,
                         output int stalls, output int reqcyc,
                         output logic stable, output logic done_seen,
                         output logic we0, output logic [5:0] addr0,
                         output logic [31:0] wdata0);
    stalls = 0; reqcyc = 0; stable = 1'b1; done_seen = 1'b0;
    we0 = 1'b0; addr0 = '0; wdata0 = '0;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      bus_ack = 1'b0;
      if (MemStall) stalls++;
      if (bus_req) begin
        if (reqcyc == 0) begin
          we0 = bus_we; addr0 = bus_addr; wdata0 = bus_wdata;
        end else if (bus_we !== we0 || bus_addr !== addr0 || bus_wdata !== wdata0) begin
          stable = 1'b0;
        end
        reqcyc++;
        if (waits >= 0 && reqcyc == waits + 1) begin
          bus_ack   = 1'b1;
          bus_rdata = rdata;
        end
      end else if (!MemStall && reqcyc > 0) begin
        done_seen = 1'b1;
        if (ack_in_done) begin
          bus_ack   = 1'b1;
          bus_rdata = 32'hBAD0_BAD0;
        end
        break;
      end
    end
  endtask

  int          st, rq;
  logic        stab, dn, we0;
  logic [5:0]  a0;
  logic [31:0] wd0;

  task automatic test_reset();
    reset = 1'b0;
    drive(0, 0, 32'h0, 32'h0);
    bus_ack = 1'b0; bus_rdata = 32'h0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus_req, bus_we, bus_addr, bus_wdata} !== 39'd0) begin
      errors++;
      $display("FAIL reset_bus: got req=%b we=%b addr=%h wdata=%h want all 0",
               bus_req, bus_we, bus_addr, bus_wdata);
    end
    checks++;
    if ({MemDout_mem, MemStall, AccessErr, BusErr} !== 35'd0) begin
      errors++;
      $display("FAIL reset_out: got dout=%h stall=%b aerr=%b berr=%b want all 0",
               MemDout_mem, MemStall, AccessErr, BusErr);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (MemStall !== 1'b0 || bus_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got stall=%b req=%b want 0 0", MemStall, bus_req);
    end
  endtask

  task automatic test_read();
    @(posedge clk); #1;
    drive(1, 0, 32'h0000_0010, 32'h0);
    run_bus(0, 32'hCAFE_0001, 1'b0, st, rq, stab, dn, we0, a0, wd0);
    checks++;
    if (dn !== 1'b1 || st != 2 || rq != 1) begin
      errors++;
      $display("FAIL read_timing: got done=%b stalls=%0d reqcyc=%0d want 1 2 1", dn, st, rq);
    end
    checks++;
    if (we0 !== 1'b0 || a0 !== 6'd4) begin
      errors++;
      $display("FAIL read_bus: got we=%b addr=%h want 0 04", we0, a0);
    end
    checks++;
    if (MemDout_mem !== 32'hCAFE_0001) begin
      errors++;
      $display("FAIL read_data: got %h want cafe0001", MemDout_mem);
    end
    @(posedge clk); #1;
    drive(0, 0, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    checks++;
    if (MemDout_mem !== 32'hCAFE_0001 || MemStall !== 1'b0) begin
      errors++;
      $display("FAIL read_hold: got dout=%h stall=%b want cafe0001 0", MemDout_mem, MemStall);
    end
  endtask

  task automatic test_write();
    @(posedge clk); #1;
    drive(0, 1, 32'h0000_0020, 32'h1234_5678);
    run_bus(3, 32'hDEAD_BEEF, 1'b0, st, rq, stab, dn, we0, a0, wd0);
    checks++;
    if (dn !== 1'b1 || st != 5 || rq != 4) begin
      errors++;
      $display("FAIL write_timing: got done=%b stalls=%0d reqcyc=%0d want 1 5 4", dn, st, rq);
    end
    checks++;
    if (we0 !== 1'b1 || a0 !== 6'd8 || wd0 !== 32'h1234_5678 || stab !== 1'b1) begin
      errors++;
      $display("FAIL write_bus: got we=%b addr=%h wdata=%h stable=%b want 1 08 12345678 1",
               we0, a0, wd0, stab);
    end
    checks++;
    if (MemDout_mem !== 32'hCAFE_0001) begin
      errors++;
      $display("FAIL write_dout_hold: got %h want cafe0001", MemDout_mem);
    end
    @(posedge clk); #1;
    drive(0, 0, 32'h0, 32'h0);
  endtask

  task automatic test_timeout();
    @(negedge clk);
    checks++;
    if (BusErr !== 1'b0) begin
      errors++;
      $display("FAIL timeout_pre: got berr=%b want 0", BusErr);
    end
    @(posedge clk); #1;
    drive(1, 0, 32'h0000_0004, 32'h0);
    run_bus(-1, 32'h0, 1'b0, st, rq, stab, dn, we0, a0, wd0);
    checks++;
    if (dn !== 1'b1 || rq != 16 || st != 17) begin
      errors++;
      $display("FAIL timeout_timing: got done=%b reqcyc=%0d stalls=%0d want 1 16 17", dn, rq, st);
    end
    checks++;
    if (BusErr !== 1'b1 || MemDout_mem !== 32'h0 || a0 !== 6'd1) begin
      errors++;
      $display("FAIL timeout_result: got berr=%b dout=%h addr=%h want 1 0 01",
               BusErr, MemDout_mem, a0);
    end
    @(posedge clk); #1;
    drive(0, 0, 32'h0, 32'h0);
    repeat (3) @(negedge clk);
    checks++;
    if (BusErr !== 1'b1 || MemStall !== 1'b0 || bus_req !== 1'b0) begin
      errors++;
      $display("FAIL timeout_sticky: got berr=%b stall=%b req=%b want 1 0 0",
               BusErr, MemStall, bus_req);
    end
  endtask

  task automatic test_back_to_back();
    @(posedge clk); #1;
    drive(1, 0, 32'h0000_0000, 32'h0);
    run_bus(0, 32'h1111_1111, 1'b1, st, rq, stab, dn, we0, a0, wd0);
    checks++;
    if (dn !== 1'b1 || st != 2 || rq != 1 || a0 !== 6'd0 || MemDout_mem !== 32'h1111_1111) begin
      errors++;
      $display("FAIL b2b_first: got done=%b stalls=%0d reqcyc=%0d addr=%h dout=%h want 1 2 1 00 11111111",
               dn, st, rq, a0, MemDout_mem);
    end
    @(posedge clk); #1;
    bus_ack = 1'b0;
    drive(1, 0, 32'h0000_0008, 32'h0);
    checks++;
    if (bus_req !== 1'b0 || MemStall !== 1'b1 || MemDout_mem !== 32'h1111_1111) begin
      errors++;
      $display("FAIL b2b_gap: got req=%b stall=%b dout=%h want 0 1 11111111",
               bus_req, MemStall, MemDout_mem);
    end
    run_bus(0, 32'h2222_2222, 1'b0, st, rq, stab, dn, we0, a0, wd0);
    checks++;
    if (dn !== 1'b1 || st != 2 || rq != 1 || a0 !== 6'd2 || MemDout_mem !== 32'h2222_2222) begin
      errors++;
      $display("FAIL b2b_second: got done=%b stalls=%0d reqcyc=%0d addr=%h dout=%h want 1 2 1 02 22222222",
               dn, st, rq, a0, MemDout_mem);
    end
    @(posedge clk); #1;
    drive(0, 0, 32'h0, 32'h0);
  endtask

  task automatic test_forbidden();
    @(posedge clk); #1;
    drive(1, 0, 32'h4000_0000, 32'h0);
    @(negedge clk);
    checks++;
    if (MemStall !== 1'b0 || bus_req !== 1'b0 || MemDout_mem !== 32'h0 || AccessErr !== 1'b0) begin
      errors++;
      $display("FAIL forbid_same_cycle: got stall=%b req=%b dout=%h aerr=%b want 0 0 0 0",
               MemStall, bus_req, MemDout_mem, AccessErr);
    end
    @(posedge clk); #1;
    drive(0, 1, 32'h4000_0010, 32'hFFFF_0000);
    @(negedge clk);
    checks++;
    if (AccessErr !== 1'b1 || bus_req !== 1'b0 || MemStall !== 1'b0) begin
      errors++;
      $display("FAIL forbid_flag: got aerr=%b req=%b stall=%b want 1 0 0",
               AccessErr, bus_req, MemStall);
    end
    @(posedge clk); #1;
    drive(0, 0, 32'h0, 32'h0);
    repeat (3) @(negedge clk);
    checks++;
    if (AccessErr !== 1'b1 || bus_req !== 1'b0 || MemDout_mem !== 32'h0) begin
      errors++;
      $display("FAIL forbid_sticky: got aerr=%b req=%b dout=%h want 1 0 0",
               AccessErr, bus_req, MemDout_mem);
    end
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    drive(1, 0, 32'h0000_000C, 32'h0);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus_req !== 1'b1 || bus_addr !== 6'd3) begin
      errors++;
      $display("FAIL rstmid_bus: got req=%b addr=%h want 1 03", bus_req, bus_addr);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (bus_req !== 1'b0 || MemStall !== 1'b0 || bus_addr !== 6'd0 ||
        AccessErr !== 1'b0 || BusErr !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_async: got req=%b stall=%b addr=%h aerr=%b berr=%b want 0 0 00 0 0",
               bus_req, MemStall, bus_addr, AccessErr, BusErr);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    run_bus(0, 32'h5A5A_5A5A, 1'b0, st, rq, stab, dn, we0, a0, wd0);
    checks++;
    if (dn !== 1'b1 || st != 2 || rq != 1 || a0 !== 6'd3 || MemDout_mem !== 32'h5A5A_5A5A) begin
      errors++;
      $display("FAIL rstmid_after: got done=%b stalls=%0d reqcyc=%0d addr=%h dout=%h want 1 2 1 03 5a5a5a5a",
               dn, st, rq, a0, MemDout_mem);
    end
    @(posedge clk); #1;
    drive(0, 0, 32'h0, 32'h0);
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_timeout();
    test_back_to_back();
    test_forbidden();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
- MEM-stage data-memory controller that replaces the single-cycle DataRam hookup with a multi-cycle req/ack bus master.
- Consumes the EX/MEM register outputs (address, write data, read/write strobes) and drives a word-addressed external data bus.
- Returns read data to MEM/WB and asserts MemStall to freeze the whole pipeline while a bus transaction is in flight.
- Enforces the forbidden 0x4xxxxxxx region and bounds every transaction with a timeout.

Parameters:
ADDR_W, 6, word-address width driven on bus_addr (taken from Addr_mem[ADDR_W+1:2])
TIMEOUT, 16, max cycles in BUS state without bus_ack before abort (>=2)
FORBID_NIB, 4'h4, Addr_mem[31:28] value whose accesses are blocked

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
MemRead_mem  in  1  load request held by EX/MEM register
MemWrite_mem  in  1  store request held by EX/MEM register
Addr_mem  in  32  byte address (ALUResult_mem)
MemWriteData_mem  in  32  store data
MemDout_mem  out  32  load data to MEM/WB
MemStall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM, MEM/WB when 1
AccessErr  out  1  sticky: forbidden-region access seen
BusErr  out  1  sticky: bus timeout seen
bus_req  out  1  transaction request, registered
bus_we  out  1  1 = write, registered
bus_addr  out  ADDR_W  word address, registered
bus_wdata  out  32  write data, registered
bus_ack  in  1  slave completion, 1-cycle pulse
bus_rdata  in  32  read data, valid with bus_ack

Behaviour:
- Reset (reset=0, async):
  - FSM goes to IDLE.
  - bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0.
  - MemDout_mem=0, AccessErr=0, BusErr=0, timeout counter=0.
  - Reset mid-transaction abandons the transaction; no completion is reported.
- Request detection:
  - req = MemRead_mem | MemWrite_mem.
  - Both strobes high is treated as a write.
  - Forbidden: Addr_mem[31:28]==FORBID_NIB.
- FSM states: IDLE, BUS, DONE.
- IDLE:
  - Legal req: MemStall=1 (combinational). At the clock edge, latch bus_we/bus_addr/bus_wdata, set bus_req=1, clear counter, go to BUS.
  - Forbidden req: MemStall=0, no bus activity, write dropped, MemDout_mem=0, AccessErr set next edge; stay in IDLE.
  - No req: MemStall=0.
- BUS:
  - MemStall=1; bus_req and bus_* held stable until exit.
  - bus_ack=1: capture bus_rdata into MemDout_mem if read (hold otherwise), drop bus_req, go to DONE.
  - Else if counter==TIMEOUT-1: drop bus_req, MemDout_mem=0, set BusErr, go to DONE.
  - Else increment counter.
- DONE:
  - MemStall=0 for exactly one cycle so the pipeline advances; MemDout_mem valid this cycle.
  - Next edge returns to IDLE unconditionally.
  - A new request is only evaluated in IDLE, so each MEM instruction produces exactly one transaction.
- Latency:
  - Zero-wait slave (ack on first BUS cycle): 2 stall cycles; data valid in DONE.
  - Each extra slave wait state adds one stall cycle.
- bus_ack received in IDLE or DONE is ignored.
- MemDout_mem holds its value between loads.
- AccessErr and BusErr are cleared only by reset.

Decomposition:
- Shared package mem_defs:
  - FSM state encoding (2-bit localparams S_IDLE/S_BUS/S_DONE).
  - FORBID_NIB default.
  - Bus timeout default.
- One sub-module, mem_timeout_cnt: counter with clear/enable that flags terminal count at TIMEOUT-1.

Test Plan:
- Read, Addr=0x0000_0010, slave acks first BUS cycle with 0xCAFE_0001 -> bus_addr=4, bus_we=0; MemStall high 2 cycles; MemDout_mem=0xCAFE_0001 in DONE.
- Write, Addr=0x0000_0020, data 0x1234_5678, slave acks after 3 wait cycles -> bus_we=1, bus_addr=8, bus_wdata=0x1234_5678 stable for 4 cycles; MemStall high 5 cycles.
- Read, Addr=0x4000_0000 -> no bus_req; MemStall stays 0; MemDout_mem=0; AccessErr=1 next edge and stays 1.
- Read, Addr=0x0000_0004, slave never acks, TIMEOUT=16 -> bus_req high 16 cycles then low; BusErr=1; MemDout_mem=0; one DONE cycle with MemStall=0.
- Back-to-back loads at 0x0 and 0x8 with zero-wait slave -> two separate bus_req pulses; pattern IDLE,BUS,DONE,IDLE,BUS,DONE; correct data each DONE; spurious bus_ack in DONE ignored.
- Reset asserted during BUS -> bus_req=0, MemStall=0, FSM in IDLE immediately; the subsequent request runs normally.
